inst_fetch_stage: RTL and testbench
===================================

// Module: inst_fetch_stage
// PURPOSE
//  IF stage of PipelineCPU: owns the PC, drives InstMem's ReadAddr and registers InstMem's ReadInst into the IF/ID pipeline register.
//  Selects next PC from exception vector, EX branch, ID jump or PC+4.
//  Honours hazard-unit Stall/Flush; feeds the ID stage.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded by reset
//  EXC_VECTOR  32'h8000_0004  exception/interrupt handler address (bit31 = kernel mode)
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  Stall          in   1   hold PC and IF/ID (load-use hazard)
//  Flush          in   1   replace IF/ID contents with bubble
//  BranchTaken    in   1   branch resolved taken in EX
//  BranchTarget   in   32  branch target from EX
//  JumpTaken      in   1   j/jal/jr resolved in ID
//  JumpTarget     in   32  jump target from ID
//  ExcReq         in   1   exception/interrupt request
//  InstAddr       out  32  PC to InstMem ReadAddr (combinational from PC reg)
//  InstData       in   32  InstMem ReadInst, same-cycle combinational return
//  IF_ID_Inst     out  32  registered instruction
//  IF_ID_PC       out  32  registered PC of IF_ID_Inst
//  IF_ID_PCPlus4  out  32  registered PC+4 (link address)
//  IF_ID_Valid    out  1   1 = real instruction, 0 = bubble
// BEHAVIOUR
//  - Reset (overrides all inputs, any cycle): PC<=RESET_PC; IF_ID_Inst/PC/PCPlus4<=0; IF_ID_Valid<=0.
//  - InstAddr = {PC[31:2],2'b00}; fetch latency 1 cycle (addr in cycle n -> IF_ID_Inst valid n+1).
//  - PC+4: bits[30:0] increment modulo 2^31, bit31 kept (0x7FFF_FFFC -> 0x0000_0000; 0xFFFF_FFFC -> 0x8000_0000).
//  - Next-PC priority: ExcReq > BranchTaken > JumpTaken > Stall(hold) > PC+4.
//    ExcReq: EXC_VECTOR. Branch: {PC[31],BranchTarget[30:2],2'b00} (cannot enter kernel).
//    Jump: {JumpTarget[31:2],2'b00} (jr may leave kernel). Target bits[1:0] ignored.
//  - Redirect (ExcReq|BranchTaken|JumpTaken) overrides Stall for PC and kills the in-flight fetch:
//    IF/ID <= bubble (Inst=0 i.e. NOP, PC=0, PCPlus4=0, Valid=0).
//  - Flush alone: IF/ID <= bubble; PC still advances (PC+4, or holds if Stall).
//  - Stall alone: PC and all IF/ID outputs hold; InstAddr unchanged.
//  - Stall&Flush, no redirect: PC holds, IF/ID <= bubble.
//  - Otherwise: IF/ID <= {InstData, PC, PC+4, 1}; PC <= PC+4.
//  - No FSM; the only state is PC + IF/ID. All outputs are glitch-free registers except InstAddr.
// CONFIGURATION
//  INST_FETCH_PERF_EN defined: adds outputs FetchCount[31:0] and StallCount[31:0].
//   FetchCount++ on each cycle IF/ID loads Valid=1. StallCount++ on each cycle with Stall & no redirect.
//   Both reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared header cpu_defs.vh: NOP encoding (32'h0), default RESET_PC/EXC_VECTOR, instruction width.
//  One sub-module: if_id_reg (IF/ID register with load/hold/bubble controls, reset to bubble).
//  Next-PC mux and PC register stay in inst_fetch_stage.
// TESTING
//  1 reset 3 cycles, release, InstData=addr-tagged -> InstAddr 0,4,8; IF_ID_PC lags by 1 cycle, Valid=1 from 2nd cycle.
//  2 at PC=0x10 assert Stall 2 cycles -> InstAddr stays 0x10, IF/ID outputs frozen; resume to 0x14.
//  3 at PC=0x20, BranchTaken=1, BranchTarget=0x103 with Stall=1 -> next PC 0x100, IF_ID_Valid=0 for that cycle.
//  4 same cycle ExcReq+BranchTaken+JumpTaken -> PC=0x8000_0004, bubble; then PC+4=0x8000_0008.
//  5 PC=0x7FFF_FFFC -> next 0x0000_0000; kernel PC=0x8000_0010 BranchTarget=0x40 -> 0x8000_0040;
//    JumpTarget=0x40 -> 0x0000_0040.
//  6 reset asserted mid-stream with Stall=1 -> PC=RESET_PC, Valid=0; with INST_FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/inst_fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding, reset/exception defaults, IF/ID payload.
package inst_fetch_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_W    = 32;

    localparam logic [INST_W-1:0] NOP_INST       = INST_W'(0);
    localparam logic [XLEN-1:0]   DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0]   DEF_EXC_VECTOR = 32'h8000_0004;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic              valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc: XLEN'(0), pc_plus4: XLEN'(0), valid: 1'b0};

    // Sequential PC: low 31 bits wrap, mode bit 31 is preserved.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
    endfunction

endpackage

// File: rtl/inst_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset/bubble > load > hold.
module inst_fetch_stage_if_id_reg
    import inst_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_load,
    input  logic   i_bubble,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_q <= IF_ID_BUBBLE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// IF stage: PC register, next-PC selection and IF/ID register.
// Optional perf counters enabled by defining INST_FETCH_PERF_EN.
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    input  logic        ExcReq,
    output logic [31:0] InstAddr,
    input  logic [31:0] InstData,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PCPlus4,
`ifdef INST_FETCH_PERF_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
`endif
    output logic        IF_ID_Valid
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic        w_bubble;
    logic        w_load;
    if_id_t      w_d;
    if_id_t      w_q;
    logic        w_unused;

    assign w_redirect = ExcReq | BranchTaken | JumpTaken;
    assign w_bubble   = w_redirect | Flush;
    assign w_load     = ~Stall;
    assign w_pc_plus4 = pc_plus4(r_pc);
    assign InstAddr   = {r_pc[31:2], 2'b00};

    // Branches keep the current mode bit; jumps (jr) may change it.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (ExcReq) begin
            w_pc_next = EXC_VECTOR;
        end else if (BranchTaken) begin
            w_pc_next = {r_pc[31], BranchTarget[30:2], 2'b00};
        end else if (JumpTaken) begin
            w_pc_next = {JumpTarget[31:2], 2'b00};
        end else if (Stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign w_d = '{inst: InstData, pc: InstAddr, pc_plus4: w_pc_plus4, valid: 1'b1};

    inst_fetch_stage_if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_d      (w_d),
        .o_q      (w_q)
    );

    assign IF_ID_Inst    = w_q.inst;
    assign IF_ID_PC      = w_q.pc;
    assign IF_ID_PCPlus4 = w_q.pc_plus4;
    assign IF_ID_Valid   = w_q.valid;

`ifdef INST_FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Fetch counts real loads into IF/ID; stall counts held cycles not overridden by a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_load && !w_bubble) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (Stall && !w_redirect) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign FetchCount = r_fetch_count;
    assign StallCount = r_stall_count;
`endif

    assign w_unused = &{1'b0, BranchTarget[31], BranchTarget[1:0], JumpTarget[1:0]};

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed scenarios then randomized traffic vs a reference model.
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        JumpTaken = 1'b0;
    logic [31:0] JumpTarget = 32'd0;
    logic        ExcReq = 1'b0;
    logic [31:0] InstAddr;
    logic [31:0] InstData;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_EXC_VEC  = 32'h8000_0004;

    always #5 clk = ~clk;

    // Instruction memory: word tagged with its own address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign InstData = mem(InstAddr);

    inst_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .Stall         (Stall),
        .Flush         (Flush),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget),
        .JumpTaken     (JumpTaken),
        .JumpTarget    (JumpTarget),
        .ExcReq        (ExcReq),
        .InstAddr      (InstAddr),
        .InstData      (InstData),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
`ifdef INST_FETCH_PERF_EN
        .FetchCount    (FetchCount),
        .StallCount    (StallCount),
`endif
        .IF_ID_Valid   (IF_ID_Valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_inst, m_ipc, m_ip4;
    logic        m_valid;
    logic [31:0] m_fc, m_sc;
    bit          m_known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    // One clock: drive controls, advance the model, check all outputs after the edge
    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic br, input logic [31:0] btg,
                        input logic jp, input logic [31:0] jtg, input logic exc);
        logic [31:0] cur;
        @(negedge clk);
        reset = rst; Stall = st; Flush = fl;
        BranchTaken = br; BranchTarget = btg;
        JumpTaken = jp; JumpTarget = jtg; ExcReq = exc;
        #1;
        if (m_known) chk("inst_addr", InstAddr, m_pc);
        cur = m_pc;
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc = TB_RESET_PC;
            m_inst = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0;
            m_fc = 0; m_sc = 0;
        end else if (exc || br || jp) begin
            if (exc)     m_pc = TB_EXC_VEC;
            else if (br) m_pc = (cur & 32'h8000_0000) | (btg & 32'h7FFF_FFFC);
            else         m_pc = jtg & 32'hFFFF_FFFC;
            m_inst = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0;
        end else begin
            if (fl) begin
                m_inst = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0;
            end else if (!st) begin
                m_inst = mem(cur); m_ipc = cur; m_ip4 = seq_pc(cur); m_valid = 1;
                m_fc++;
            end
            if (st) m_sc++;
            else    m_pc = seq_pc(cur);
        end
        m_known = 1;
        chk("if_id_inst", IF_ID_Inst, m_inst);
        chk("if_id_pc", IF_ID_PC, m_ipc);
        chk("if_id_pc4", IF_ID_PCPlus4, m_ip4);
        chk("if_id_valid", 32'(IF_ID_Valid), 32'(m_valid));
        chk("pc_after", InstAddr, m_pc);
`ifdef INST_FETCH_PERF_EN
        chk("fetch_count", FetchCount, m_fc);
        chk("stall_count", StallCount, m_sc);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // 1: reset, then sequential fetch
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 32'(IF_ID_Valid), 32'd0);
        chk("reset_pc", InstAddr, 32'h0);
        run(2);
        chk("seq_addr8", InstAddr, 32'h8);
        chk("seq_ifid_pc4", IF_ID_PC, 32'h4);
        run(2);
        // 2: stall at 0x10
        chk("at_0x10", InstAddr, 32'h10);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_hold", InstAddr, 32'h10);
        chk("stall_ifid", IF_ID_PC, 32'hC);
        run(1);
        chk("resume", InstAddr, 32'h14);
        run(3);
        // 3: branch with stall at 0x20
        chk("at_0x20", InstAddr, 32'h20);
        step(0, 1, 0, 1, 32'h103, 0, 0, 0);
        chk("branch_pc", InstAddr, 32'h100);
        chk("branch_bubble", 32'(IF_ID_Valid), 32'd0);
        // 4: simultaneous redirects; exception wins
        step(0, 0, 0, 1, 32'h200, 1, 32'h300, 1);
        chk("exc_pc", InstAddr, 32'h8000_0004);
        run(1);
        chk("exc_seq", InstAddr, 32'h8000_0008);
        // 5: mode-bit handling and wrap
        run(2);
        chk("kernel_0x10", InstAddr, 32'h8000_0010);
        step(0, 0, 0, 1, 32'h40, 0, 0, 0);
        chk("kernel_branch", InstAddr, 32'h8000_0040);
        step(0, 0, 0, 0, 0, 1, 32'h41, 0);
        chk("jump_user", InstAddr, 32'h0000_0040);
        step(0, 0, 0, 0, 0, 1, 32'h7FFF_FFFC, 0);
        run(1);
        chk("wrap_user", InstAddr, 32'h0);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
        run(1);
        chk("wrap_kernel", InstAddr, 32'h8000_0000);
        chk("wrap_ifid_pc4", IF_ID_PCPlus4, 32'h8000_0000);
        // Flush alone and Stall+Flush
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        run(2);
        // 6: reset mid-stream while stalled
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("midreset_pc", InstAddr, TB_RESET_PC);
        chk("midreset_valid", 32'(IF_ID_Valid), 32'd0);
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 29) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
